// File: rtl/vigenere_stream_cipher.sv
// ---------------------------------------------------------------------------
// vigenere_stream_cipher
//
// Streaming Vigenere engine. A table of KEY_LEN shift values (each 0..25) is
// loaded while idle, then characters stream through one per cycle. Letters are
// shifted by the current key slot (upper/lower case preserved) and advance the
// key index; every other byte passes unchanged and leaves the index alone.
//
// Ports:
//   clk, rst          clock; synchronous active-high reset
//   mode              0 = encrypt, 1 = decrypt (captured on start)
//   key_len           active key length (captured on start, 0 -> 1,
//                     values above KEY_LEN clamp to KEY_LEN)
//   key_wr/key_addr/key_data   key slot write port, idle state only
//   start / stop      enter / leave the streaming state
//   in_valid/in_ready/in_char  input byte handshake
//   out_valid/out_ready/out_char  registered output byte handshake
//   busy              high while streaming
// ---------------------------------------------------------------------------
module vigenere_stream_cipher #(
  parameter int KEY_LEN = 4,
  parameter int KIDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mode,
  input  logic [KIDX_W:0]   key_len,
  input  logic              key_wr,
  input  logic [KIDX_W-1:0] key_addr,
  input  logic [4:0]        key_data,
  input  logic              start,
  input  logic              stop,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_char,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_char,
  output logic              busy
);

  typedef enum logic [0:0] {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [KIDX_W:0] LEN_MAX = (KIDX_W+1)'(KEY_LEN);

  state_t              state_r;
  logic [4:0]          key_r [KEY_LEN];
  logic [KIDX_W:0]     len_r;
  logic [KIDX_W-1:0]   idx_r;
  logic                mode_r;
  logic                out_valid_r;
  logic [7:0]          out_char_r;

  logic                in_ready_s;
  logic                accept_s;
  logic                letter_s;
  logic                idx_last_s;
  logic [4:0]          key_cur_s;
  logic [7:0]          xform_s;
  logic [KIDX_W:0]     len_clamp_s;

  // Reduce a 5-bit value (0..31) to 0..25.
  function automatic logic [4:0] mod26(input logic [4:0] v);
    if (v >= 5'd26) begin
      mod26 = v - 5'd26;
    end else begin
      mod26 = v;
    end
  endfunction

  function automatic logic is_lower(input logic [7:0] c);
    return (c >= 8'h61) && (c <= 8'h7A);
  endfunction

  function automatic logic is_upper(input logic [7:0] c);
    return (c >= 8'h41) && (c <= 8'h5A);
  endfunction

  // Shift a letter within its own case; k is already 0..25 so a single
  // conditional subtract keeps the 6-bit offset inside 0..25.
  function automatic logic [7:0] shift_char(input logic [7:0] c,
                                            input logic [4:0] k,
                                            input logic       dec);
    logic [7:0] base;
    logic [7:0] diff;
    logic [5:0] sum;
    if (is_lower(c)) begin
      base = 8'h61;
    end else begin
      base = 8'h41;
    end
    diff = c - base;
    if (dec) begin
      sum = diff[5:0] + 6'd26 - {1'b0, k};
    end else begin
      sum = diff[5:0] + {1'b0, k};
    end
    if (sum >= 6'd26) begin
      sum = sum - 6'd26;
    end else begin
      sum = sum;
    end
    if (is_lower(c) || is_upper(c)) begin
      shift_char = base + {2'b00, sum};
    end else begin
      shift_char = c;
    end
  endfunction

  // Handshake, transform and key-length clamping.
  always_comb begin
    in_ready_s = (state_r == ST_RUN) && (!out_valid_r || out_ready);
    accept_s   = in_valid && in_ready_s;
    letter_s   = is_lower(in_char) || is_upper(in_char);
    key_cur_s  = key_r[idx_r];
    xform_s    = shift_char(in_char, key_cur_s, mode_r);
    idx_last_s = ({1'b0, idx_r} == (len_r - (KIDX_W+1)'(1)));
    if (key_len == {(KIDX_W+1){1'b0}}) begin
      len_clamp_s = (KIDX_W+1)'(1);
    end else if (key_len > LEN_MAX) begin
      len_clamp_s = LEN_MAX;
    end else begin
      len_clamp_s = key_len;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_char  = out_char_r;
  assign busy      = (state_r == ST_RUN);

  // Control FSM, key table, key index and the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_LOAD;
      for (int i = 0; i < KEY_LEN; i++) begin
        key_r[i] <= 5'd0;
      end
      len_r       <= (KIDX_W+1)'(1);
      mode_r      <= 1'b0;
      idx_r       <= {KIDX_W{1'b0}};
      out_valid_r <= 1'b0;
      out_char_r  <= 8'h00;
    end else begin
      case (state_r)
        ST_LOAD: begin
          if (key_wr) begin
            key_r[key_addr] <= mod26(key_data);
          end
          if (start) begin
            mode_r  <= mode;
            len_r   <= len_clamp_s;
            idx_r   <= {KIDX_W{1'b0}};
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
          // A byte accepted in the stop cycle is still processed normally.
          if (stop) begin
            state_r <= ST_LOAD;
          end
          if (accept_s && letter_s) begin
            idx_r <= idx_last_s ? {KIDX_W{1'b0}} : idx_r + KIDX_W'(1);
          end
        end
        default: begin
          state_r <= ST_LOAD;
        end
      endcase

      // Output stage: load on accept, otherwise drain when the sink takes it.
      if (accept_s) begin
        out_valid_r <= 1'b1;
        out_char_r  <= xform_s;
      end else if (out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vigenere_stream_cipher.sv
module tb_vigenere_stream_cipher;

  logic       clk = 1'b0;
  logic       rst, mode, key_wr, start, stop, in_valid, out_ready;
  logic [3:0] key_len;
  logic [2:0] key_addr;
  logic [4:0] key_data;
  logic [7:0] in_char;
  logic       in_ready, out_valid, busy;
  logic [7:0] out_char;
  logic       in_ready4, out_valid4, busy4;
  logic [7:0] out_char4;

  int errors = 0;
  int checks = 0;

  // Reference model state (8-slot and 4-slot instances)
  int  mkey[8];
  int  mkey4[4];
  int  mlen, mlen4, midx, midx4;
  bit  mmode, in_load;
  logic [7:0] exp_q[$];
  logic [7:0] exp4_q[$];
  logic [7:0] in_q[$];
  int  last_cycles;

  vigenere_stream_cipher #(.KEY_LEN(8), .KIDX_W(3)) dut (
    .clk(clk), .rst(rst), .mode(mode), .key_len(key_len), .key_wr(key_wr),
    .key_addr(key_addr), .key_data(key_data), .start(start), .stop(stop),
    .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
    .out_valid(out_valid), .out_ready(out_ready), .out_char(out_char), .busy(busy));

  vigenere_stream_cipher #(.KEY_LEN(4), .KIDX_W(2)) dut4 (
    .clk(clk), .rst(rst), .mode(mode), .key_len(key_len[2:0]), .key_wr(key_wr),
    .key_addr(key_addr[1:0]), .key_data(key_data), .start(start), .stop(stop),
    .in_valid(in_valid), .in_ready(in_ready4), .in_char(in_char),
    .out_valid(out_valid4), .out_ready(out_ready), .out_char(out_char4), .busy(busy4));

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic bit is_letter(logic [7:0] c);
    return (c >= 8'd97 && c <= 8'd122) || (c >= 8'd65 && c <= 8'd90);
  endfunction

  function automatic logic [7:0] xf(logic [7:0] c, int k, bit dec);
    int base, off;
    if (c >= 8'd97 && c <= 8'd122) base = 97;
    else if (c >= 8'd65 && c <= 8'd90) base = 65;
    else return c;
    off = int'(c) - base;
    off = dec ? (off - k + 26) % 26 : (off + k) % 26;
    return 8'(base + off);
  endfunction

  function automatic void model_push(logic [7:0] c);
    exp_q.push_back(xf(c, mkey[midx], mmode));
    exp4_q.push_back(xf(c, mkey4[midx4], mmode));
    if (is_letter(c)) begin
      midx  = (midx + 1) % mlen;
      midx4 = (midx4 + 1) % mlen4;
    end
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) mkey[i] = 0;
    for (int i = 0; i < 4; i++) mkey4[i] = 0;
    mlen = 1; mlen4 = 1; midx = 0; midx4 = 0; mmode = 0; in_load = 1;
    exp_q.delete(); exp4_q.delete();
  endfunction

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic load_str(input string s);
    in_q.delete();
    for (int i = 0; i < s.len(); i++) in_q.push_back(s[i]);
  endtask

  task automatic write_key(input int slot, input int val);
    key_wr = 1'b1; key_addr = 3'(slot); key_data = 5'(val);
    tick;
    key_wr = 1'b0;
    if (in_load) begin
      mkey[slot] = val % 26;
      mkey4[slot % 4] = val % 26;
    end
  endtask

  task automatic start_run(input bit m, input int kl);
    int kl4;
    start = 1'b1; mode = m; key_len = 4'(kl);
    tick;
    start = 1'b0;
    mmode = m;
    mlen = (kl == 0) ? 1 : ((kl > 8) ? 8 : kl);
    kl4 = kl % 8;
    mlen4 = (kl4 == 0) ? 1 : ((kl4 > 4) ? 4 : kl4);
    midx = 0; midx4 = 0; in_load = 0;
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL start_busy: busy=%b want 1", busy);
    end
  endtask

  task automatic stop_run;
    stop = 1'b1;
    tick;
    stop = 1'b0;
    in_load = 1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL stop_state: busy=%b in_ready=%b want 0 0", busy, in_ready);
    end
  endtask

  task automatic go_load;
    if (!in_load) stop_run;
  endtask

  // Streams in_q through the DUT and scoreboards the outputs.
  task automatic run_stream(input bit rnd, input bit chk4, input string want);
    logic [7:0] gotq[$];
    int pos, cyc;
    bit fire_in, ok;
    foreach (in_q[i]) model_push(in_q[i]);
    pos = 0; cyc = 0;
    while ((pos < in_q.size() || exp_q.size() != 0) && cyc < 2000) begin
      in_valid  = (pos < in_q.size()) && (!rnd || $urandom_range(0, 3) != 0);
      in_char   = (pos < in_q.size()) ? in_q[pos] : 8'h00;
      out_ready = !rnd || ($urandom_range(0, 3) != 0);
      #4;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL stream_extra: got %h with nothing expected", out_char);
        end else begin
          if (out_char !== exp_q[0]) begin
            errors++; $display("FAIL stream_char: got %h want %h", out_char, exp_q[0]);
          end
          if (chk4) begin
            checks++;
            if (out_valid4 !== 1'b1 || out_char4 !== exp4_q[0]) begin
              errors++; $display("FAIL stream_char4: got %h (v=%b) want %h", out_char4, out_valid4, exp4_q[0]);
            end
          end
          gotq.push_back(out_char);
          void'(exp_q.pop_front());
          if (exp4_q.size() != 0) void'(exp4_q.pop_front());
        end
      end
      fire_in = in_valid && in_ready;
      @(posedge clk); #1;
      if (fire_in) pos++;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    last_cycles = cyc;
    checks++;
    if (cyc >= 2000) begin
      errors++; $display("FAIL stream_timeout: %0d outputs outstanding", exp_q.size());
    end
    #4;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL stream_drain: out_valid=%b want 0", out_valid);
    end
    @(posedge clk); #1;
    if (want.len() != 0) begin
      checks++;
      ok = (gotq.size() == want.len());
      if (ok) foreach (gotq[i]) if (gotq[i] !== want[i]) ok = 0;
      if (!ok) begin
        errors++; $display("FAIL stream_text: got %0d chars, want \"%s\"", gotq.size(), want);
      end
    end
    in_q.delete();
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    model_reset();
    checks++;
    if (busy !== 1'b0 || busy4 !== 1'b0) begin
      errors++; $display("FAIL reset_busy: busy=%b busy4=%b want 0", busy, busy4);
    end
    checks++;
    if (in_ready !== 1'b0 || in_ready4 !== 1'b0) begin
      errors++; $display("FAIL reset_in_ready: %b %b want 0", in_ready, in_ready4);
    end
    checks++;
    if (out_valid !== 1'b0 || out_char !== 8'h00) begin
      errors++; $display("FAIL reset_out: valid=%b char=%h want 0 00", out_valid, out_char);
    end
    stop = 1'b1; tick; stop = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL load_stop_ignored: busy=%b want 0", busy);
    end
  endtask

  task automatic test_caesar;
    go_load;
    write_key(0, 3);
    start_run(0, 1);
    load_str("hello");
    run_stream(0, 0, "khoor");
    checks++;
    if (last_cycles != 6) begin
      errors++; $display("FAIL caesar_throughput: cycles=%0d want 6", last_cycles);
    end
  endtask

  task automatic test_lemon;
    go_load;
    write_key(0, 11); write_key(1, 4); write_key(2, 12); write_key(3, 14); write_key(4, 13);
    start_run(0, 5);
    load_str("ATTACKATDAWN");
    run_stream(1, 0, "LXFOPVEFRNHR");
    stop_run;
    start_run(1, 5);
    load_str("LXFOPVEFRNHR");
    run_stream(1, 0, "ATTACKATDAWN");
  endtask

  task automatic test_nonletter;
    go_load;
    write_key(0, 1); write_key(1, 2);
    start_run(0, 2);
    load_str("a b!a");
    run_stream(0, 0, "b d!b");
    stop_run;
    write_key(0, 3);
    start_run(0, 1);
    load_str("zY");
    run_stream(0, 0, "cB");
  endtask

  task automatic test_backpressure;
    go_load;
    write_key(0, 1); write_key(1, 2);
    start_run(0, 2);
    model_push(8'h61);
    in_valid = 1'b1; in_char = 8'h61; out_ready = 1'b0;
    tick;
    in_char = 8'h62;
    for (int i = 0; i < 3; i++) begin
      #4;
      checks++;
      if (out_valid !== 1'b1 || out_char !== exp_q[0] || in_ready !== 1'b0) begin
        errors++; $display("FAIL backpressure_hold: valid=%b char=%h in_ready=%b want 1 %h 0",
                           out_valid, out_char, in_ready, exp_q[0]);
      end
      @(posedge clk); #1;
    end
    load_str("bcd");
    run_stream(0, 0, "bddf");
  endtask

  task automatic test_key_rules;
    go_load;
    write_key(0, 29);
    start_run(0, 1);
    load_str("a");
    run_stream(0, 0, "d");
    write_key(0, 5);
    load_str("ab");
    run_stream(0, 0, "de");
    stop_run;
    write_key(0, 3); write_key(1, 9);
    start_run(0, 0);
    load_str("ab");
    run_stream(0, 0, "de");
    stop_run;
    for (int s = 4; s < 8; s++) write_key(s, s + 1);
    for (int s = 0; s < 4; s++) write_key(s, s + 1);
    start_run(0, 7);
    load_str("aaaaaaaa");
    run_stream(0, 1, "bcdefghb");
    stop_run;
    start_run(0, 15);
    load_str("aaaaaaaaa");
    run_stream(0, 1, "bcdefghib");
  endtask

  task automatic test_stop_restart;
    go_load;
    write_key(0, 1); write_key(1, 2);
    start_run(0, 2);
    load_str("a");
    run_stream(0, 0, "b");
    stop_run;
    start_run(0, 2);
    load_str("a");
    run_stream(0, 0, "b");
    // Byte presented in the stop cycle is still accepted and delivered.
    model_push(8'h63);
    in_valid = 1'b1; in_char = 8'h63; stop = 1'b1; out_ready = 1'b1;
    tick;
    in_valid = 1'b0; stop = 1'b0; in_load = 1;
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b1 || out_char !== exp_q[0]) begin
      errors++; $display("FAIL stop_cycle_accept: busy=%b in_ready=%b valid=%b char=%h want 0 0 1 %h",
                         busy, in_ready, out_valid, out_char, exp_q[0]);
    end
    void'(exp_q.pop_front()); void'(exp4_q.pop_front());
    tick;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("FAIL stop_drain: out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_random;
    for (int it = 0; it < 6; it++) begin
      go_load;
      for (int j = 0; j < 8; j++) write_key(j, int'($urandom_range(0, 31)));
      start_run(bit'($urandom_range(0, 1)), int'($urandom_range(0, 15)));
      in_q.delete();
      for (int j = 0; j < 24; j++) begin
        case ($urandom_range(0, 3))
          0: in_q.push_back(8'($urandom_range(97, 122)));
          1: in_q.push_back(8'($urandom_range(65, 90)));
          2: in_q.push_back(8'($urandom_range(32, 64)));
          default: in_q.push_back(8'($urandom_range(91, 96)));
        endcase
      end
      run_stream(1, 1, "");
    end
  endtask

  task automatic test_reset_midstream;
    go_load;
    write_key(0, 7); write_key(1, 9);
    start_run(0, 2);
    in_valid = 1'b1; in_char = 8'h71; out_ready = 1'b0;
    tick;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset_valid: out_valid=%b want 1", out_valid);
    end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    model_reset();
    out_ready = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || out_char !== 8'h00 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errors++; $display("FAIL midstream_reset: valid=%b char=%h busy=%b in_ready=%b want 0 00 0 0",
                         out_valid, out_char, busy, in_ready);
    end
    start_run(0, 8);
    load_str("Hi z");
    run_stream(0, 1, "Hi z");
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; key_len = 4'd0; key_wr = 1'b0; key_addr = 3'd0;
    key_data = 5'd0; start = 1'b0; stop = 1'b0; in_valid = 1'b0; in_char = 8'h00;
    out_ready = 1'b0;
    test_reset;
    test_caesar;
    test_lemon;
    test_nonletter;
    test_backpressure;
    test_key_rules;
    test_stop_restart;
    test_random;
    test_reset_midstream;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
